// File: rtl/lcd_bus_responder_if.sv
// HD44780-style LCD bus: host-driven strobe/control/data plus the responder's read-back lines.
interface lcd_bus_responder_if;
  logic [7:0] LCD_DATA;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;
  logic [7:0] oLCD_DQ;
  logic       oLCD_DQ_OE;

  modport master (
    output LCD_DATA, LCD_RW, LCD_EN, LCD_RS,
    input  oLCD_DQ, oLCD_DQ_OE
  );

  modport slave (
    input  LCD_DATA, LCD_RW, LCD_EN, LCD_RS,
    output oLCD_DQ, oLCD_DQ_OE
  );
endinterface

// File: rtl/lcd_bus_responder.sv
// LCD-side responder for an HD44780-style bus: decodes writes on EN fall, keeps a 2x16
// DDRAM image, address counter and busy flag, and answers status/data read cycles.
module lcd_bus_responder #(
  parameter int BUSY_SHORT = 2000,
  parameter int BUSY_LONG  = 82000
) (
  input  logic                iCLK,
  input  logic                iRST,
  lcd_bus_responder_if.slave  bus,
  output logic                oBUSY,
  output logic [6:0]          oAC,
  output logic                oDISP_ON,
  output logic                oCMD_VALID,
  output logic                oDATA_VALID,
  output logic                oOVERRUN,
  input  logic [4:0]          iRD_ADDR,
  output logic [7:0]          oRD_CHAR
);

  localparam int              CW        = $clog2(BUSY_LONG + 1);
  localparam logic [CW-1:0]   SHORT_CNT = CW'(BUSY_SHORT);
  localparam logic [CW-1:0]   LONG_CNT  = CW'(BUSY_LONG);
  localparam logic [CW-1:0]   TAIL_CNT  = CW'(BUSY_LONG - 32);
  localparam logic [7:0]      BLANK     = 8'h20;

  typedef enum logic [1:0] {CLEAR, IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic [4:0]    clr_idx;
  logic [CW-1:0] busy_cnt;
  logic          clr_cmd;

  logic [7:0] data_s1, data_s2;
  logic       rs_s1, rs_s2, rw_s1, rw_s2;
  logic       en_s1, en_s2, en_s3, armed;

  logic [6:0] ac;
  logic       inc_mode, cg_mode, disp_on;
  logic       cmd_valid, data_valid, overrun;
  logic [7:0] dq, rd_char;
  logic       dq_oe;
  logic [7:0] ddram [32];

  logic       fall, wr_fire, rd_fire, drop, is_clear, is_home;
  logic       ac_mapped, read_cycle;
  logic [4:0] ddram_idx;
  logic [7:0] rd_value;

  // EN syncs reset high and 'armed' waits for EN low, so a strobe cut by reset never fires.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      data_s1 <= '0;
      data_s2 <= '0;
      rs_s1   <= 1'b0;
      rs_s2   <= 1'b0;
      rw_s1   <= 1'b0;
      rw_s2   <= 1'b0;
      en_s1   <= 1'b1;
      en_s2   <= 1'b1;
      en_s3   <= 1'b1;
      armed   <= 1'b0;
    end else begin
      data_s1 <= bus.LCD_DATA;
      data_s2 <= data_s1;
      rs_s1   <= bus.LCD_RS;
      rs_s2   <= rs_s1;
      rw_s1   <= bus.LCD_RW;
      rw_s2   <= rw_s1;
      en_s1   <= bus.LCD_EN;
      en_s2   <= en_s1;
      en_s3   <= en_s2;
      armed   <= armed | ~en_s2;
    end
  end

  assign fall       = en_s3 & ~en_s2 & armed;
  assign wr_fire    = fall & ~rw_s2 & (state == IDLE);
  assign rd_fire    = fall & rw_s2 & rs_s2 & (state == IDLE);
  assign drop       = fall & (state != IDLE) & (~rw_s2 | rs_s2);
  assign is_clear   = ~rs_s2 & (data_s2 == 8'h01);
  assign is_home    = ~rs_s2 & (data_s2[7:1] == 7'h01);
  assign read_cycle = armed & en_s2 & rw_s2;
  assign ac_mapped  = ~cg_mode & (ac[5:4] == 2'b00);
  assign ddram_idx  = {ac[6], ac[3:0]};
  assign rd_value   = ac_mapped ? ddram[ddram_idx] : BLANK;

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27)      return 7'h40;
      else if (a == 7'h67) return 7'h00;
      else                 return a + 7'd1;
    end else begin
      if (a == 7'h40)      return 7'h27;
      else if (a == 7'h00) return 7'h67;
      else                 return a - 7'd1;
    end
  endfunction

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= CLEAR;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_idx == 5'd31) state_next = clr_cmd ? BUSY : IDLE;
      IDLE:    if (wr_fire) state_next = is_clear ? CLEAR : BUSY;
      BUSY:    if (busy_cnt <= CW'(1)) state_next = IDLE;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    oBUSY = 1'b1;
    if (state == IDLE) oBUSY = 1'b0;
  end

  // The clear sweep takes 32 cycles, so a clear command only loads the remainder of its long delay.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      clr_idx  <= '0;
      busy_cnt <= '0;
      clr_cmd  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 5'd1;
          if (clr_idx == 5'd31) busy_cnt <= clr_cmd ? TAIL_CNT : '0;
        end
        IDLE: begin
          if (wr_fire) begin
            busy_cnt <= (is_clear | is_home) ? LONG_CNT : SHORT_CNT;
            clr_cmd  <= is_clear;
          end
        end
        BUSY:    busy_cnt <= busy_cnt - CW'(1);
        default: busy_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (state == CLEAR)
      ddram[clr_idx] <= BLANK;
    else if (wr_fire & rs_s2 & ac_mapped)
      ddram[ddram_idx] <= data_s2;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ac         <= '0;
      inc_mode   <= 1'b1;
      cg_mode    <= 1'b0;
      disp_on    <= 1'b0;
      cmd_valid  <= 1'b0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      dq         <= '0;
      dq_oe      <= 1'b0;
      rd_char    <= BLANK;
    end else begin
      cmd_valid  <= wr_fire & ~rs_s2;
      data_valid <= wr_fire & rs_s2;
      if (drop) overrun <= 1'b1;
      dq_oe      <= read_cycle;
      dq         <= read_cycle ? (rs_s2 ? rd_value : {oBUSY, ac}) : 8'h00;
      rd_char    <= ddram[iRD_ADDR];
      if (rd_fire) begin
        ac <= ac_step(ac, inc_mode);
      end else if (wr_fire) begin
        if (rs_s2) begin
          ac <= ac_step(ac, inc_mode);
        end else begin
          // Instructions decode by their highest set bit.
          casez (data_s2)
            8'b1???????: begin
              ac      <= data_s2[6:0];
              cg_mode <= 1'b0;
            end
            8'b01??????: cg_mode <= 1'b1;
            8'b001?????: ;
            8'b0001????: if (!data_s2[3]) ac <= data_s2[2] ? ac + 7'd1 : ac - 7'd1;
            8'b00001???: disp_on <= data_s2[2];
            8'b000001??: inc_mode <= data_s2[1];
            8'b0000001?: ac <= '0;
            8'b00000001: begin
              ac       <= '0;
              inc_mode <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign oAC            = ac;
  assign oDISP_ON       = disp_on;
  assign oCMD_VALID     = cmd_valid;
  assign oDATA_VALID    = data_valid;
  assign oOVERRUN       = overrun;
  assign oRD_CHAR       = rd_char;
  assign bus.oLCD_DQ    = dq;
  assign bus.oLCD_DQ_OE = dq_oe;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder: table of instruction/data writes plus
// hand-written sequences for reset, clear timing, overrun, read cycles and reset mid-strobe.
module tb_lcd_bus_responder;

  localparam int BUSY_SHORT = 20;
  localparam int BUSY_LONG  = 200;
  localparam int IDLE_WAIT  = BUSY_LONG + 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy, disp_on, cmd_valid, data_valid, overrun;
  logic [6:0] ac;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [7:0] dq;
  logic       oe;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cmd_pulses  = 0;
  int data_pulses = 0;

  lcd_bus_responder_if bus();

  lcd_bus_responder #(.BUSY_SHORT(BUSY_SHORT), .BUSY_LONG(BUSY_LONG)) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .bus         (bus),
    .oBUSY       (busy),
    .oAC         (ac),
    .oDISP_ON    (disp_on),
    .oCMD_VALID  (cmd_valid),
    .oDATA_VALID (data_valid),
    .oOVERRUN    (overrun),
    .iRD_ADDR    (rd_addr),
    .oRD_CHAR    (rd_char)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1)  cmd_pulses++;
    if (data_valid === 1'b1) data_pulses++;
  end

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [6:0] exp_ac;
    logic       exp_disp;
  } vec_t;

  vec_t vecs [15];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic apply_stimulus(input logic rs, input logic [7:0] data);
    @(negedge clk);
    bus.LCD_RS   = rs;
    bus.LCD_RW   = 1'b0;
    bus.LCD_DATA = data;
    bus.LCD_EN   = 1'b1;
    repeat (4) @(negedge clk);
    bus.LCD_EN   = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < IDLE_WAIT) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(busy), 32'd0);
  endtask

  task automatic write_idle(input logic rs, input logic [7:0] data);
    apply_stimulus(rs, data);
    wait_idle("wait_idle");
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] rdq, output logic roe);
    @(negedge clk);
    bus.LCD_RS = rs;
    bus.LCD_RW = 1'b1;
    bus.LCD_EN = 1'b1;
    repeat (3) @(negedge clk);
    rdq = bus.oLCD_DQ;
    roe = bus.oLCD_DQ_OE;
    @(negedge clk);
    bus.LCD_EN = 1'b0;
    repeat (4) @(negedge clk);
    bus.LCD_RW = 1'b0;
  endtask

  task automatic read_char(input int idx, output logic [7:0] v);
    @(negedge clk);
    rd_addr = 5'(idx);
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic check_all_chars(input string name, input logic [7:0] lo, input logic [7:0] hi);
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      read_char(i, v);
      check_output($sformatf("%s[%0d]", name, i), 32'(v), 32'((i < 16) ? lo : hi));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, m, c0, d0;
    logic [7:0] v;

    vecs[0]  = '{1'b0, 8'h38, 7'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'h0C, 7'h00, 1'b1};
    vecs[2]  = '{1'b0, 8'h06, 7'h00, 1'b1};
    vecs[3]  = '{1'b0, 8'h80, 7'h00, 1'b1};
    vecs[4]  = '{1'b0, 8'h08, 7'h00, 1'b0};
    vecs[5]  = '{1'b0, 8'h0C, 7'h00, 1'b1};
    vecs[6]  = '{1'b0, 8'h8E, 7'h0E, 1'b1};
    vecs[7]  = '{1'b1, 8'h61, 7'h0F, 1'b1};
    vecs[8]  = '{1'b0, 8'h14, 7'h10, 1'b1};
    vecs[9]  = '{1'b0, 8'h10, 7'h0F, 1'b1};
    vecs[10] = '{1'b0, 8'h1C, 7'h0F, 1'b1};
    vecs[11] = '{1'b0, 8'h02, 7'h00, 1'b1};
    vecs[12] = '{1'b0, 8'h40, 7'h00, 1'b1};
    vecs[13] = '{1'b1, 8'h62, 7'h01, 1'b1};
    vecs[14] = '{1'b0, 8'h80, 7'h00, 1'b1};

    bus.LCD_EN = 1'b0;
    bus.LCD_RW = 1'b0;
    bus.LCD_RS = 1'b0;
    bus.LCD_DATA = 8'h00;
    rd_addr = 5'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check_output("rst_busy", 32'(busy), 32'd1);
    check_output("rst_ac", 32'(ac), 32'd0);
    check_output("rst_disp", 32'(disp_on), 32'd0);
    check_output("rst_overrun", 32'(overrun), 32'd0);
    check_output("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check_output("rst_data_valid", 32'(data_valid), 32'd0);
    check_output("rst_dq_oe", 32'(bus.oLCD_DQ_OE), 32'd0);
    check_output("rst_dq", 32'(bus.oLCD_DQ), 32'd0);
    check_output("rst_rd_char", 32'(rd_char), 32'h20);

    rst = 1'b0;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_output("por_busy_len", 32'(n), 32'd32);
    check_output("por_ac", 32'(ac), 32'd0);
    check_all_chars("por_char", 8'h20, 8'h20);

    for (int i = 0; i < 15; i++) begin
      c0 = cmd_pulses;
      d0 = data_pulses;
      apply_stimulus(vecs[i].rs, vecs[i].data);
      check_output($sformatf("vec%0d_ac", i), 32'(ac), 32'(vecs[i].exp_ac));
      check_output($sformatf("vec%0d_disp", i), 32'(disp_on), 32'(vecs[i].exp_disp));
      check_output($sformatf("vec%0d_cmd_pulse", i), 32'(cmd_pulses - c0), vecs[i].rs ? 32'd0 : 32'd1);
      check_output($sformatf("vec%0d_data_pulse", i), 32'(data_pulses - d0), vecs[i].rs ? 32'd1 : 32'd0);
      wait_idle($sformatf("vec%0d_idle", i));
    end
    read_char(14, v);
    check_output("vec_ddram14", 32'(v), 32'h61);
    read_char(0, v);
    check_output("cg_write_ddram0", 32'(v), 32'h20);
    read_char(1, v);
    check_output("cg_write_ddram1", 32'(v), 32'h20);
    check_output("vec_overrun", 32'(overrun), 32'd0);

    write_idle(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) write_idle(1'b1, 8'h31);
    write_idle(1'b0, 8'hC0);
    for (int i = 0; i < 16; i++) write_idle(1'b1, 8'h32);
    check_output("fill_ac", 32'(ac), 32'h50);
    check_all_chars("fill_char", 8'h31, 8'h32);
    check_output("fill_overrun", 32'(overrun), 32'd0);

    write_idle(1'b0, 8'hA7);
    check_output("wrap_set_ac", 32'(ac), 32'h27);
    write_idle(1'b1, 8'h41);
    check_output("wrap_inc_27", 32'(ac), 32'h40);
    write_idle(1'b0, 8'hE7);
    write_idle(1'b1, 8'h44);
    check_output("wrap_inc_67", 32'(ac), 32'h00);
    check_all_chars("wrap_char", 8'h31, 8'h32);
    write_idle(1'b0, 8'h04);
    write_idle(1'b0, 8'h80);
    write_idle(1'b1, 8'h42);
    check_output("wrap_dec_00", 32'(ac), 32'h67);
    read_char(0, v);
    check_output("wrap_dec_ddram0", 32'(v), 32'h42);
    write_idle(1'b0, 8'hC0);
    write_idle(1'b1, 8'h43);
    check_output("wrap_dec_40", 32'(ac), 32'h27);
    read_char(16, v);
    check_output("wrap_dec_ddram16", 32'(v), 32'h43);
    write_idle(1'b0, 8'h06);

    check_output("pre_clear_overrun", 32'(overrun), 32'd0);
    d0 = data_pulses;
    @(negedge clk);
    bus.LCD_RS = 1'b0;
    bus.LCD_RW = 1'b0;
    bus.LCD_DATA = 8'h01;
    bus.LCD_EN = 1'b1;
    repeat (4) @(negedge clk);
    bus.LCD_EN = 1'b0;
    n = 0;
    fork
      begin
        m = 0;
        while (m < BUSY_LONG + 100) begin
          @(negedge clk);
          m++;
          if (busy === 1'b1) n++;
          else if (n > 0) break;
        end
      end
      begin
        repeat (6) @(negedge clk);
        bus.LCD_RS = 1'b1;
        bus.LCD_DATA = 8'h55;
        bus.LCD_EN = 1'b1;
        repeat (4) @(negedge clk);
        bus.LCD_EN = 1'b0;
        repeat (4) @(negedge clk);
      end
    join
    check_output("clear_busy_len", 32'(n), 32'(BUSY_LONG));
    check_output("clear_overrun", 32'(overrun), 32'd1);
    check_output("clear_no_data_pulse", 32'(data_pulses - d0), 32'd0);
    check_output("clear_ac", 32'(ac), 32'd0);
    check_all_chars("clear_char", 8'h20, 8'h20);

    apply_stimulus(1'b0, 8'h85);
    bus_read(1'b0, dq, oe);
    check_output("busy_read_oe", 32'(oe), 32'd1);
    check_output("busy_read_dq", 32'(dq), 32'h85);
    check_output("busy_read_oe_off", 32'(bus.oLCD_DQ_OE), 32'd0);
    wait_idle("busy_read_idle");
    bus_read(1'b0, dq, oe);
    check_output("idle_read_dq", 32'(dq), 32'h05);
    write_idle(1'b1, 8'h5A);
    check_output("rd_setup_ac", 32'(ac), 32'h06);
    write_idle(1'b0, 8'h85);
    bus_read(1'b1, dq, oe);
    check_output("data_read_oe", 32'(oe), 32'd1);
    check_output("data_read_dq", 32'(dq), 32'h5A);
    check_output("data_read_ac_step", 32'(ac), 32'h06);

    d0 = data_pulses;
    apply_stimulus(1'b0, 8'h8A);
    check_output("mid_busy_ac", 32'(ac), 32'h0A);
    @(negedge clk);
    bus.LCD_RS = 1'b1;
    bus.LCD_RW = 1'b0;
    bus.LCD_DATA = 8'h77;
    bus.LCD_EN = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("mid_rst_busy", 32'(busy), 32'd1);
    check_output("mid_rst_ac", 32'(ac), 32'd0);
    check_output("mid_rst_overrun", 32'(overrun), 32'd0);
    check_output("mid_rst_disp", 32'(disp_on), 32'd0);
    check_output("mid_rst_rd_char", 32'(rd_char), 32'h20);
    rst = 1'b0;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 4) bus.LCD_EN = 1'b0;
      @(negedge clk);
    end
    bus.LCD_EN = 1'b0;
    check_output("mid_rst_busy_len", 32'(n), 32'd32);
    repeat (6) @(negedge clk);
    check_output("mid_rst_strobe_overrun", 32'(overrun), 32'd0);
    check_output("mid_rst_strobe_pulse", 32'(data_pulses - d0), 32'd0);
    check_output("mid_rst_ac_after", 32'(ac), 32'd0);
    check_all_chars("mid_rst_char", 8'h20, 8'h20);
    write_idle(1'b0, 8'h0C);
    check_output("recover_disp", 32'(disp_on), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Synthesizable HD44780-style responder: the LCD side of the bus that the LCD_Controller drives.
- Decodes instruction and data writes on the falling edge of LCD_EN.
- Maintains a 2x16 DDRAM image, an address counter (AC) and a busy flag, and answers read cycles.
- Used as an on-chip bench and loopback target, so display-driver sequences can be checked without a physical panel.

Parameters:
- BUSY_SHORT, 2000: busy cycles after any normal instruction or data write (40 us at 50 MHz).
- BUSY_LONG, 82000: busy cycles after clear-display or return-home (1.64 ms at 50 MHz).

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  reset; asynchronous, active-high.
- LCD_DATA  in  8  bus data from host.
- LCD_RW  in  1  1 = read, 0 = write.
- LCD_EN  in  1  strobe.
- LCD_RS  in  1  0 = instruction, 1 = data.
- oLCD_DQ  out  8  read-back data.
- oLCD_DQ_OE  out  1  read-back drive enable.
- oBUSY  out  1  busy flag.
- oAC  out  7  address counter.
- oDISP_ON  out  1  display-on bit D.
- oCMD_VALID  out  1  1-cycle pulse, instruction accepted.
- oDATA_VALID  out  1  1-cycle pulse, data byte accepted.
- oOVERRUN  out  1  sticky: write arrived while busy.
- iRD_ADDR  in  5  debug DDRAM index (0-15 line 1, 16-31 line 2).
- oRD_CHAR  out  8  DDRAM[iRD_ADDR], registered, 1-cycle latency.

Behaviour:
- **Input timing:**
  - All bus inputs pass through 2-flop synchronizers; a third EN register forms the edge detector.
  - A falling EN edge is detected 3 iCLK after the pin falls. RS, RW and DATA are taken from the same synchronizer stage as EN.
  - Host obligations: EN high ≥3 cycles, EN low ≥3 cycles, data stable until 3 cycles after EN falls.
- **Reset values:** oBUSY=1, oAC=0, oDISP_ON=0, I/D=1, cg_mode=0, oOVERRUN=0, oCMD_VALID=0, oDATA_VALID=0, oLCD_DQ=0, oLCD_DQ_OE=0, oRD_CHAR=0x20. The FSM enters CLEAR.
- **FSM states:** CLEAR, IDLE, BUSY.
  - CLEAR writes 0x20 to DDRAM entries 0..31, one per cycle (32 cycles), then loads the busy counter.
    - After reset: load 0 and go to IDLE.
    - After a clear command: load BUSY_LONG-32 and go to BUSY.
  - BUSY decrements the counter; at 0 go to IDLE. oBUSY=1 in CLEAR and BUSY.
- **Writes (RW=0) on a detected EN fall:**
  - In IDLE: executed; oCMD_VALID or oDATA_VALID pulses in the next cycle; the FSM enters BUSY with BUSY_SHORT, or BUSY_LONG for clear/home.
  - Otherwise: discarded, oOVERRUN set, no valid pulse.
- **Instruction decode** by the highest set bit:
  - 0x01 clear: AC=0, I/D=1, go to CLEAR.
  - 0x02/0x03 home: AC=0.
  - 0000_01xx entry mode: I/D=bit1; S ignored.
  - 0000_1xxx display control: oDISP_ON=bit2.
  - 0001_xxxx shift: if S/C=0, AC += 1 for R/L=1, or AC −= 1 for R/L=0; if S/C=1, no effect.
  - 001x_xxxx function set: accepted, no state change.
  - 01xx_xxxx CGRAM address: cg_mode=1.
  - 1xxx_xxxx DDRAM address: AC=DATA[6:0], cg_mode=0.
- **Data write:**
  - If cg_mode=0 and AC is in 0x00-0x0F or 0x40-0x4F, store to DDRAM index {AC[6], AC[3:0]}; otherwise discard.
  - AC then steps per I/D in both cases.
- **AC stepping (2-line map):**
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x40→0x27, 0x00→0x67.
  - Other values step by 1.
- **Reads (RW=1):**
  - While synchronized EN=1, oLCD_DQ_OE=1.
  - RS=0: oLCD_DQ={oBUSY, AC}. Reading the busy flag is legal while busy.
  - RS=1: oLCD_DQ=DDRAM at AC (0x20 if unmapped). AC steps per I/D on the EN fall. Ignored if busy, and oOVERRUN is set.
- **Reset mid-operation:** iRST asserted during CLEAR, BUSY or an EN strobe aborts immediately; the partial strobe is never executed.
- **Simultaneous events:** if an EN fall coincides with the busy counter reaching 0, the write is treated as arriving while busy.

Test Plan:
- Reset release: oBUSY=1 for 32 cycles then 0; oRD_CHAR=0x20 for all 32 indices; oAC=0.
- Instruction writes 0x38, 0x0C, 0x06, 0x80 with busy polled between each: oDISP_ON=1, oAC=0x00, 4 oCMD_VALID pulses, oOVERRUN=0.
- Sequence 0x80, then data 0x31 ×16, then 0xC0, then 0x32 ×16: DDRAM[0..15]=0x31, DDRAM[16..31]=0x32; final oAC=0x50.
- AC wrap: 0xA7 then data 0x41: index unchanged, oAC=0x40. Entry mode 0x04, 0x80, data 0x42: oAC=0x67.
- Clear after filled display: oBUSY high exactly BUSY_LONG cycles; all chars 0x20; oAC=0. A data write 10 cycles in gives oOVERRUN=1 and no DDRAM change.
- Read busy flag: RW=1, RS=0 during BUSY gives oLCD_DQ[7]=1 and oLCD_DQ[6:0]=oAC. iRST pulse mid-BUSY gives oBUSY=1, then the CLEAR sequence repeats.
